// File: rtl/uart_rx_if.sv
// Receive-side bundle for uart_rx: serial line in, parallel byte and status out.
// rcv is a one-cycle valid with no ready (no backpressure); data/ferr/perr stay stable from one rcv to the next.
`timescale 1ns/1ps
interface uart_rx_if;
  logic       rx;
  logic [7:0] data;
  logic       rcv;
  logic       ferr;
  logic       perr;
  logic       busy;
  logic [2:0] state_dbg;

  modport slave  (input rx, output data, rcv, ferr, perr, busy, state_dbg);
  modport master (output rx, input data, rcv, ferr, perr, busy, state_dbg);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a per-frame restarted bit timer.
// Define UART_RX_PARITY_EN to receive 8E1 frames and report parity errors on perr.
`timescale 1ns/1ps
module uart_rx #(
  parameter int BAUDRATE = 1250
) (
  input logic     clk,
  input logic     rstn,
  uart_rx_if.slave bus
);
  localparam int            CW   = $clog2(BAUDRATE);
  localparam logic [CW-1:0] HALF = CW'(BAUDRATE / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(BAUDRATE - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [1:0]    sync_q;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          armed;
  logic [7:0]    data_q;
  logic          rcv_q;
  logic          ferr_q;
`ifdef UART_RX_PARITY_EN
  logic          par_q;
  logic          perr_q;
`endif

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], bus.rx};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (armed && !rx_s) state_n = S_START;
      S_START: if (cnt == HALF) state_n = rx_s ? S_IDLE : S_DATA;
      S_DATA: begin
        if (cnt == LAST && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_n = S_PARITY;
`else
          state_n = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (cnt == LAST) state_n = S_STOP;
`endif
      S_STOP:  if (cnt == LAST) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Timer restarts on each state entry and at every bit boundary so
  // non-power-of-two divisors keep their period.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                cnt <= '0;
    else if (state_n != state || cnt == LAST) cnt <= '0;
    else                                      cnt <= cnt + CW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      armed   <= 1'b0;
      bit_idx <= 3'd0;
      shreg   <= 8'h00;
      data_q  <= 8'h00;
      rcv_q   <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q   <= 1'b0;
      perr_q  <= 1'b0;
`endif
    end else begin
      rcv_q <= 1'b0;
      armed <= 1'b0;
      case (state)
        S_IDLE: begin
          if (state_n == S_IDLE) armed <= armed | rx_s;
        end
        S_START: begin
          if (state_n == S_DATA) bit_idx <= 3'd0;
        end
        S_DATA: begin
          if (cnt == LAST) begin
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end
        end
`ifdef UART_RX_PARITY_EN
        S_PARITY: begin
          if (cnt == LAST) par_q <= rx_s;
        end
`endif
        S_STOP: begin
          if (cnt == LAST) begin
            rcv_q  <= 1'b1;
            data_q <= shreg;
            ferr_q <= ~rx_s;
`ifdef UART_RX_PARITY_EN
            perr_q <= (^shreg) ^ par_q;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.data      = data_q;
  assign bus.rcv       = rcv_q;
  assign bus.ferr      = ferr_q;
  assign bus.busy      = (state != S_IDLE);
  assign bus.state_dbg = state;
`ifdef UART_RX_PARITY_EN
  assign bus.perr      = perr_q;
`else
  assign bus.perr      = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at BAUDRATE=16: directed table, corner-case sequences and random frames
// checked through an expected-byte queue filled from a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx;
  localparam int B = 16;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int EXP_LAT = 2 + B / 2 + (PAR_EN ? 10 : 9) * B + 1;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  uart_rx_if bus ();

  uart_rx #(.BAUDRATE(B)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;
  int cycle_cnt = 0;
  int rcv_count = 0;
  int last_rcv_cycle = 0;
  int start_cycle = 0;
  logic [9:0] exp_q[$];
  logic [9:0] exp_v;

  typedef struct {
    logic [7:0] d;
    logic       par;
    logic       stop;
    logic       exp_ferr;
    logic       exp_perr;
  } vec_t;
  vec_t tbl[7];

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Frame-level reference: byte as sent, ferr from stop bit, even-parity check when enabled.
  function automatic logic [9:0] model(input logic [7:0] d, input logic par, input logic stop);
    logic perr;
    perr = PAR_EN ? ((^d) ^ par) : 1'b0;
    return {perr, ~stop, d};
  endfunction

  always @(negedge clk) begin
    if (rstn === 1'b1 && bus.rcv === 1'b1) begin
      rcv_count++;
      last_rcv_cycle = cycle_cnt;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_rcv actual data=%h required no pulse", bus.data);
      end else begin
        exp_v = exp_q.pop_front();
        check("rx_byte", {22'b0, bus.perr, bus.ferr, bus.data}, {22'b0, exp_v});
      end
    end
  end

  task automatic drive_bit(input logic b);
    bus.rx = b;
    repeat (B) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    start_cycle = cycle_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    if (PAR_EN) drive_bit(par);
    drive_bit(stop);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   base;
    logic saw;
    logic [7:0] d;
    logic par, stop;

    tbl[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'h07, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'h07, 1'b0, 1'b1, 1'b0, 1'b1};
    tbl[5] = '{8'h81, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[6] = '{8'hC3, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset values
    bus.rx = 1'b1;
    rstn   = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data", {24'b0, bus.data}, 32'h0);
    check("reset_rcv",  {31'b0, bus.rcv},  32'h0);
    check("reset_ferr", {31'b0, bus.ferr}, 32'h0);
    check("reset_perr", {31'b0, bus.perr}, 32'h0);
    check("reset_busy", {31'b0, bus.busy}, 32'h0);
    rstn = 1'b1;
    repeat (4) @(negedge clk);

    // Directed table, frames back-to-back with no idle gap
    for (int i = 0; i < 7; i++) begin
      exp_q.push_back({tbl[i].exp_perr & PAR_EN, tbl[i].exp_ferr, tbl[i].d});
      send_frame(tbl[i].d, tbl[i].par, tbl[i].stop);
      if (i == 0) check("latency", last_rcv_cycle - start_cycle, EXP_LAT);
    end
    check("table_rcv_count", rcv_count, 7);
    drive_bit(1'b1);

    // Short low glitch on an idle line
    base = rcv_count;
    saw  = 1'b0;
    bus.rx = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 3) bus.rx = 1'b1;
      saw |= bus.busy;
      if (k == B / 2 + 3) check("glitch_busy_clear", {31'b0, bus.busy}, 32'h0);
    end
    check("glitch_busy_seen", {31'b0, saw}, 32'h1);
    check("glitch_no_rcv", rcv_count, base);

    // Break: stop bit 0, line held low afterwards
    base = rcv_count;
    exp_q.push_back({1'b0, 1'b1, 8'h3C});
    send_frame(8'h3C, 1'b0, 1'b0);
    saw = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      saw |= bus.busy;
    end
    check("break_no_restart", {31'b0, saw}, 32'h0);
    check("break_rcv_count", rcv_count, base + 1);
    drive_bit(1'b1);
    exp_q.push_back(model(8'h11, 1'b0, 1'b1));
    send_frame(8'h11, 1'b0, 1'b1);
    drive_bit(1'b1);

    // Reset during data bit 4 aborts the frame
    base = rcv_count;
    d = 8'hC6;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(d[i]);
    bus.rx = d[4];
    repeat (B / 2) @(negedge clk);
    rstn   = 1'b0;
    bus.rx = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_data_cleared", {24'b0, bus.data}, 32'h0);
    check("abort_busy", {31'b0, bus.busy}, 32'h0);
    rstn = 1'b1;
    repeat (2 * B) @(negedge clk);
    check("abort_no_rcv", rcv_count, base);
    check("abort_data_held", {24'b0, bus.data}, 32'h0);
    exp_q.push_back(model(8'h5A, 1'b0, 1'b1));
    send_frame(8'h5A, 1'b0, 1'b1);
    drive_bit(1'b1);
    check("abort_next_rcv", rcv_count, base + 1);

    // Random frames, occasional bad stop bits, short random gaps
    for (int n = 0; n < 20; n++) begin
      d    = 8'($urandom_range(0, 255));
      par  = 1'($urandom_range(0, 1));
      stop = ($urandom_range(0, 3) != 0);
      exp_q.push_back(model(d, par, stop));
      send_frame(d, par, stop);
      if (!stop) drive_bit(1'b1);
      else begin
        bus.rx = 1'b1;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end

    repeat (2 * B) @(negedge clk);
    check("drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
